// File: rtl/knn_sp_stream_reader.sv
// Streams a contiguous block of search-point rows from the local_SP URAM
// to the distance stage, issuing reads only when the output FIFO has room.
module knn_sp_stream_reader #(
   parameter int DATA_WIDTH   = 256,
   parameter int ADDR_WIDTH   = 11,
   parameter int READ_LATENCY = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   num_rows,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] mem_address0,
   output logic                  mem_ce0,
   output logic                  mem_we0,
   output logic [DATA_WIDTH-1:0] mem_d0,
   input  logic [DATA_WIDTH-1:0] mem_q0,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH:0] ONE_C = (ADDR_WIDTH+1)'(1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } state_t;

   state_t state;
   state_t state_n;

   logic [ADDR_WIDTH-1:0]   issue_addr;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [ADDR_WIDTH:0]     issue_left;
   logic [ADDR_WIDTH:0]     emit_left;
   logic [READ_LATENCY-1:0] vsr;
   logic [READ_LATENCY-1:0] vsr_n;
   logic [CW-1:0]           inflight;
   logic [CW-1:0]           fifo_count;
   logic [PW-1:0]           wr_ptr;
   logic [PW-1:0]           rd_ptr;
   logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
   logic [CW:0]             credit_used;
   logic                    issue;
   logic                    push;
   logic                    pop;
   logic                    accept;

   // Credit check uses registered occupancy so ce0 has no path from out_ready.
   always_comb begin
      credit_used = {1'b0, fifo_count} + {1'b0, inflight};
      issue  = (state == ISSUE) && (issue_left != '0) &&
               (credit_used < DEPTH_C);
      push   = vsr[READ_LATENCY-1];
      pop    = out_valid && out_ready;
      accept = (state == IDLE) && start;
      vsr_n    = vsr << 1;
      vsr_n[0] = issue;
   end

   // Next-state logic; start is only looked at in IDLE.
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (start)
               state_n = (num_rows == '0) ? DONE : ISSUE;
         end
         ISSUE: begin
            if (issue && issue_left == ONE_C)
               state_n = DRAIN;
         end
         DRAIN: begin
            if (pop && emit_left == ONE_C)
               state_n = DONE;
         end
         DONE: begin
            state_n = IDLE;
         end
      endcase
   end

   // Outputs; address holds the last issued row while ce0 is low.
   always_comb begin
      busy         = (state == ISSUE) || (state == DRAIN);
      done         = (state == DONE);
      mem_ce0      = issue;
      mem_address0 = issue ? issue_addr : addr_q;
      mem_we0      = 1'b0;
      mem_d0       = '0;
      out_valid    = (fifo_count != '0);
      out_data     = out_valid ? fifo_mem[rd_ptr] : '0;
      out_last     = out_valid && (emit_left == ONE_C);
   end

   // State, counters, in-flight tags and FIFO pointers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         issue_addr <= '0;
         addr_q     <= '0;
         issue_left <= '0;
         emit_left  <= '0;
         vsr        <= '0;
         inflight   <= '0;
         fifo_count <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
      end else begin
         state    <= state_n;
         vsr      <= vsr_n;
         inflight <= inflight + CW'(issue) - CW'(push);
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         if (accept && num_rows != '0) begin
            issue_addr <= base_addr;
            issue_left <= num_rows;
            emit_left  <= num_rows;
         end else begin
            if (issue) begin
               addr_q     <= issue_addr;
               issue_addr <= issue_addr + ADDR_WIDTH'(1);
               issue_left <= issue_left - ONE_C;
            end
            if (pop)
               emit_left <= emit_left - ONE_C;
         end
      end
   end

   // FIFO storage; stale contents are unreachable once pointers reset.
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= mem_q0;
   end

endmodule

// File: tb/tb_knn_sp_stream_reader.sv
// Scoreboard bench for knn_sp_stream_reader: a table of block reads on a
// RL=1/FIFO=4 instance plus reset, restart and a full-block RL=3 run.
module tb_knn_sp_stream_reader;

   localparam int DW = 256;
   localparam int AW = 11;
   localparam int FD_A = 4;
   localparam logic [DW-1:0] JUNK = {8{32'hDEADBEEF}};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          start_a, start_b;
   logic [AW-1:0] base_a, base_b;
   logic [AW:0]   num_a, num_b;
   logic          busy_a, busy_b, done_a, done_b;
   logic [AW-1:0] addr_a, addr_b;
   logic          ce_a, ce_b, we_a, we_b;
   logic [DW-1:0] d_a, d_b, q_a, q_b, data_a, data_b;
   logic          valid_a, valid_b, ready_a, ready_b, last_a, last_b;

   knn_sp_stream_reader #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
      .READ_LATENCY(1), .FIFO_DEPTH(FD_A)
   ) dut_a (
      .clk(clk), .reset(reset), .start(start_a),
      .base_addr(base_a), .num_rows(num_a),
      .busy(busy_a), .done(done_a),
      .mem_address0(addr_a), .mem_ce0(ce_a),
      .mem_we0(we_a), .mem_d0(d_a), .mem_q0(q_a),
      .out_data(data_a), .out_valid(valid_a),
      .out_ready(ready_a), .out_last(last_a)
   );

   knn_sp_stream_reader #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
      .READ_LATENCY(3), .FIFO_DEPTH(8)
   ) dut_b (
      .clk(clk), .reset(reset), .start(start_b),
      .base_addr(base_b), .num_rows(num_b),
      .busy(busy_b), .done(done_b),
      .mem_address0(addr_b), .mem_ce0(ce_b),
      .mem_we0(we_b), .mem_d0(d_b), .mem_q0(q_b),
      .out_data(data_b), .out_valid(valid_b),
      .out_ready(ready_b), .out_last(last_b)
   );

   function automatic logic [DW-1:0] row(input logic [AW-1:0] a);
      row = DW'(a) * DW'(3);
   endfunction

   // Memory models: registered read, junk when not enabled.
   logic [DW-1:0] pa;
   logic [DW-1:0] pb [3];
   always @(posedge clk) begin
      pa    <= ce_a ? row(addr_a) : JUNK;
      pb[0] <= ce_b ? row(addr_b) : JUNK;
      pb[1] <= pb[0];
      pb[2] <= pb[1];
   end
   assign q_a = pa;
   assign q_b = pb[2];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } beat_t;

   beat_t         qa[$];
   logic [AW-1:0] qaddr[$];
   logic [DW-1:0] qb[$];

   int outs_a = 0, beats_a = 0, dones_a = 0, done_cyc_a = 0;
   int start_cyc = 0, busy_seen = 0;
   bit hold_a = 0;
   logic [DW-1:0] hold_d;
   int beats_b = 0, dones_b = 0, done_cyc_b = 0, first_b = 0;
   int last_cyc_b = 0, gap_b = 0, start_cyc_b = 0;
   int rmode = 0, rph = 0;

   // Monitor A: address order, credit bound, beats, stability, done.
   always @(negedge clk) begin
      if (ce_a) begin
         outs_a++;
         chk("credit_bound", DW'(outs_a <= FD_A), DW'(1));
         if (qaddr.size() == 0)
            chk("ce_unexpected", DW'(1), DW'(0));
         else
            chk("ce_addr", DW'(addr_a), DW'(qaddr.pop_front()));
      end
      if (hold_a) begin
         chk("hold_valid", DW'(valid_a), DW'(1));
         chk("hold_data", data_a, hold_d);
      end
      hold_a = valid_a && !ready_a;
      hold_d = data_a;
      if (valid_a && ready_a) begin
         beat_t e;
         outs_a--;
         beats_a++;
         if (qa.size() == 0) begin
            chk("beat_unexpected", DW'(1), DW'(0));
         end else begin
            e = qa.pop_front();
            chk("beat_data", data_a, e.d);
            chk("beat_last", DW'(last_a), DW'(e.l));
         end
      end
      if (done_a) begin
         dones_a++;
         done_cyc_a = cyc - start_cyc;
      end
      if (busy_a) busy_seen = 1;
   end

   // Monitor B: in-order data, back-to-back beats, done.
   always @(negedge clk) begin
      if (valid_b && ready_b) begin
         if (beats_b > 0 && cyc != last_cyc_b + 1) gap_b++;
         if (beats_b == 0) first_b = cyc - start_cyc_b;
         last_cyc_b = cyc;
         beats_b++;
         if (qb.size() == 0)
            chk("b_unexpected", DW'(1), DW'(0));
         else
            chk("b_data", data_b, qb.pop_front());
         chk("b_last", DW'(last_b), DW'(beats_b == 2048));
      end
      if (done_b) begin
         dones_b++;
         done_cyc_b = cyc - start_cyc_b;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
      case (rmode)
         0: ready_a = 1'b1;
         1: ready_a = (rph % 4 == 0) || (rph % 4 == 3);
         2: ready_a = 1'($urandom_range(0, 1));
         default: ready_a = 1'b0;
      endcase
      rph++;
   endtask

   task automatic expect_a(input logic [AW-1:0] base, input int num);
      logic [AW-1:0] a;
      for (int i = 0; i < num; i++) begin
         a = base + AW'(i);
         qaddr.push_back(a);
         qa.push_back('{d: row(a), l: (i == num - 1)});
      end
   endtask

   task automatic cmd_a(input logic [AW-1:0] base, input int num);
      expect_a(base, num);
      dones_a = 0;
      beats_a = 0;
      busy_seen = 0;
      rph = 0;
      start_a = 1'b1;
      base_a = base;
      num_a = (AW+1)'(num);
      start_cyc = cyc;
      tick();
      start_a = 1'b0;
   endtask

   task automatic wait_done_a(input string name);
      for (int k = 0; k < 400 && dones_a == 0; k++) tick();
      if (dones_a == 0) chk({name, "_timeout"}, DW'(0), DW'(1));
      repeat (5) tick();
   endtask

   typedef struct {
      logic [AW-1:0] base;
      int            num;
      int            mode;
      int            exp_done;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{base: 11'd10,   num: 4,  mode: 0, exp_done: 7};
      vecs[1] = '{base: 11'd0,    num: 8,  mode: 1, exp_done: -1};
      vecs[2] = '{base: 11'd2046, num: 4,  mode: 0, exp_done: 7};
      vecs[3] = '{base: 11'd5,    num: 0,  mode: 0, exp_done: 1};
      vecs[4] = '{base: 11'd100,  num: 1,  mode: 0, exp_done: 4};
      vecs[5] = '{base: 11'd2040, num: 20, mode: 2, exp_done: -1};

      reset = 1'b0;
      start_a = 1'b0; base_a = '0; num_a = '0; ready_a = 1'b1;
      start_b = 1'b0; base_b = '0; num_b = '0; ready_b = 1'b1;
      repeat (3) tick();
      chk("rst_busy", DW'(busy_a), DW'(0));
      chk("rst_done", DW'(done_a), DW'(0));
      chk("rst_ce", DW'(ce_a), DW'(0));
      chk("rst_valid", DW'(valid_a), DW'(0));
      chk("rst_addr", DW'(addr_a), DW'(0));
      chk("rst_we", DW'(we_a), DW'(0));
      reset = 1'b1;
      tick();

      for (int n = 0; n < 6; n++) begin
         rmode = vecs[n].mode;
         cmd_a(vecs[n].base, vecs[n].num);
         wait_done_a($sformatf("v%0d", n));
         chk($sformatf("v%0d_dones", n), DW'(dones_a), DW'(1));
         chk($sformatf("v%0d_beats", n), DW'(beats_a), DW'(vecs[n].num));
         chk($sformatf("v%0d_sb_empty", n),
             DW'(qa.size() + qaddr.size()), DW'(0));
         chk($sformatf("v%0d_busy", n), DW'(busy_seen),
             DW'(vecs[n].num != 0));
         if (vecs[n].exp_done >= 0)
            chk($sformatf("v%0d_done_cyc", n), DW'(done_cyc_a),
                DW'(vecs[n].exp_done));
      end

      // Reset mid-run with three reads outstanding and ready low.
      rmode = 3;
      cmd_a(11'd50, 16);
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk("mid_rst_busy", DW'(busy_a), DW'(0));
      chk("mid_rst_done", DW'(done_a), DW'(0));
      chk("mid_rst_ce", DW'(ce_a), DW'(0));
      chk("mid_rst_valid", DW'(valid_a), DW'(0));
      chk("mid_rst_last", DW'(last_a), DW'(0));
      chk("mid_rst_addr", DW'(addr_a), DW'(0));
      chk("mid_rst_data", data_a, DW'(0));
      reset = 1'b1;
      qa.delete();
      qaddr.delete();
      outs_a = 0;
      hold_a = 0;
      rmode = 0;
      repeat (4) begin
         tick();
         chk("post_rst_valid", DW'(valid_a), DW'(0));
         chk("post_rst_data", data_a, DW'(0));
      end

      // Restart, with a stray start while busy.
      cmd_a(11'd0, 2);
      start_a = 1'b1;
      base_a = 11'd700;
      num_a = 12'd5;
      tick();
      start_a = 1'b0;
      wait_done_a("restart");
      chk("restart_dones", DW'(dones_a), DW'(1));
      chk("restart_beats", DW'(beats_a), DW'(2));
      chk("restart_done_cyc", DW'(done_cyc_a), DW'(5));
      chk("restart_sb_empty", DW'(qa.size() + qaddr.size()), DW'(0));

      // Full address space at RL=3, FIFO=8.
      for (int i = 0; i < 2048; i++) qb.push_back(row(AW'(i)));
      start_b = 1'b1;
      base_b = '0;
      num_b = 12'd2048;
      start_cyc_b = cyc;
      tick();
      start_b = 1'b0;
      for (int k = 0; k < 3000 && dones_b == 0; k++) tick();
      if (dones_b == 0) chk("full_timeout", DW'(0), DW'(1));
      repeat (5) tick();
      chk("full_beats", DW'(beats_b), DW'(2048));
      chk("full_dones", DW'(dones_b), DW'(1));
      chk("full_gaps", DW'(gap_b), DW'(0));
      chk("full_first_cyc", DW'(first_b), DW'(5));
      chk("full_done_cyc", DW'(done_cyc_b), DW'(2053));
      chk("full_sb_empty", DW'(qb.size()), DW'(0));

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/knn_sp_stream_reader.md
Name: knn_sp_stream_reader

Overview:
- Downstream consumer of the per-kernel local_SP search-point URAM (256-bit x 2048, single port, registered read).
- On a start command, reads a contiguous block of rows through the memory's read port and emits them in order on a valid/ready stream toward the distance-compute stage.
- Credit-limited issue into an output FIFO guarantees no read data is ever dropped under backpressure.

Parameters:
- DATA_WIDTH, 256, width of one search-point row.
- ADDR_WIDTH, 11, memory address width; the address space is 2^ADDR_WIDTH rows.
- READ_LATENCY, 1, cycles from ce0 to valid q0. Legal range 1..3.
- FIFO_DEPTH, 4, output FIFO entries. Must be a power of 2 and at least READ_LATENCY+2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous reset, active-low.
- start  in  1  one-cycle command pulse; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first row to read; captured on an accepted start.
- num_rows  in  ADDR_WIDTH+1  row count, 0..2^ADDR_WIDTH; captured on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the last row has been accepted downstream.
- mem_address0  out  ADDR_WIDTH  memory address.
- mem_ce0  out  1  memory read enable.
- mem_we0  out  1  write enable; constant 0.
- mem_d0  out  DATA_WIDTH  write data; constant 0.
- mem_q0  in  DATA_WIDTH  memory read data, valid READ_LATENCY cycles after ce0.
- out_data  out  DATA_WIDTH  row data.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_last  out  1  high with the final row of the block.

Behaviour:
- Reset (reset==0 at a clock edge), applied in any state:
  - state returns to IDLE.
  - busy, done, mem_ce0, out_valid, out_last = 0; mem_address0 = 0.
  - FIFO emptied, in-flight valid shift register cleared, counters zeroed.
  - Read data already in flight at reset is discarded.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1, num_rows>0: capture base_addr and num_rows into issue_addr, issue_left and emit_left; go to ISSUE.
  - start=1, num_rows=0: go to DONE with no memory access.
- ISSUE: a read is issued in a cycle iff issue_left>0 and (fifo_count + inflight) < FIFO_DEPTH, with both terms as registered values.
  - On issue: mem_ce0=1, mem_address0=issue_addr; then issue_addr increments and issue_left decrements.
  - issue_addr wraps modulo 2^ADDR_WIDTH, so 2047 is followed by 0.
  - The cycle issue_left reaches 0, go to DRAIN.
- mem_ce0 is combinational from the registered state and counters; mem_address0 is held while ce0=0.
- In-flight tracking: a READ_LATENCY-deep valid shift register tagged by ce0. When a tag exits, mem_q0 is written into the FIFO.
- FIFO: first-word-fall-through.
  - out_valid = (fifo_count != 0).
  - Push and pop in the same cycle leave the count unchanged.
  - Overflow cannot occur; the bench asserts this.
- out_last = out_valid && (emit_left == 1). emit_left decrements on each accepted beat.
- DRAIN: when the beat with out_last is accepted, go to DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE. A start in the DONE cycle is ignored.
- busy = 1 in ISSUE and DRAIN.
- start outside IDLE is ignored; captured values are not disturbed.
- Latency, with start accepted at cycle 0 and out_ready held at 1:
  - first mem_ce0 at cycle 1.
  - first out_valid at cycle 2+READ_LATENCY.
  - one beat per cycle thereafter.
  - done in the cycle after the last beat is accepted.
- Throughput: one row per cycle with out_ready held at 1, guaranteed by FIFO_DEPTH >= READ_LATENCY+2.
- out_data and out_valid are stable while out_valid && !out_ready.

Test Plan:
- Basic run (RL=1): memory row i = i*3, base=10, num_rows=4, out_ready=1.
  - ce0 at cycles 1-4 with addresses 10-13.
  - beats 30, 33, 36, 39 at cycles 3-6; out_last on 39; done at cycle 7.
- Backpressure: num_rows=8, out_ready toggling 1,0,0,1 repeating.
  - all 8 rows delivered in order with no drop or duplicate.
  - fifo_count + inflight never exceeds 4.
  - no ce0 while credits are exhausted.
- Wrap: base=2046, num_rows=4.
  - addresses 2046, 2047, 0, 1 in order.
  - out_last on the fourth beat.
- Zero-length: start with num_rows=0.
  - no ce0.
  - done pulses at cycle 1 and busy stays 0.
- Reset and command robustness:
  - reset=0 for one cycle mid-run with 3 reads in flight: all outputs 0 next cycle and stale data never appears on out_data.
  - a subsequent start with base=0, num_rows=2 produces exactly rows 0 and 1.
  - a start pulsed while busy is ignored.
- Full block at RL=3, FIFO_DEPTH=8: num_rows=2048, out_ready=1.
  - 2048 consecutive beats at one per cycle.
  - done exactly once.
